mem_port_arbiter: RTL and testbench

- Shares the single-port 32x8 program/data memory between the CPU datapath port and an external loader/debug port.
- Sequences each memory access as issue, wait, then respond.
- Arbitrates with CPU priority and a starvation guard for the external port.
- Produces `cpu_stall`, which freezes the phase counter while the CPU waits for memory.

---
 rtl/veririsc_pkg.sv | 17 +
 rtl/arb_starve_cnt.sv | 35 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/veririsc_pkg.sv
// Shared types and constants for the memory port arbiter and its neighbours.
// Holds the arbiter state enum, grant encodings and memory geometry.
package veririsc_pkg;

    localparam int MEM_AWIDTH = 5;
    localparam int MEM_DWIDTH = 8;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_EXT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of arbitration rounds lost by the external port.
// Ports: clk/rst (async active-low), inc_i, clr_i (wins), sat_o at MAX.
module arb_starve_cnt #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign sat_o = (cnt_q == 4'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU and an external port.
// Ports: cpu_*/ext_* request/ack pairs, mem_* memory side, clk, rst (async low).
module mem_port_arbiter
    import veririsc_pkg::*;
#(
    parameter int AWIDTH   = MEM_AWIDTH,
    parameter int DWIDTH   = MEM_DWIDTH,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_wr,
    input  logic [AWIDTH-1:0] ext_addr,
    input  logic [DWIDTH-1:0] ext_wdata,
    output logic [DWIDTH-1:0] ext_rdata,
    output logic              ext_ack,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ext_ack_q, ext_ack_d;
    logic [DWIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DWIDTH-1:0] ext_rdata_q, ext_rdata_d;

    logic c_req;
    logic e_req;
    logic ext_wins;
    logic cnt_inc;
    logic cnt_clr;
    logic starve_sat;

    // A port whose ack is showing has just finished; keep it out of this round.
    assign c_req = cpu_req & ~cpu_ack_q;
    assign e_req = ext_req & ~ext_ack_q;

    assign ext_wins = e_req & (~c_req | starve_sat);

    arb_starve_cnt #(
        .MAX(MAX_WAIT)
    ) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc_i(cnt_inc),
        .clr_i(cnt_clr),
        .sat_o(starve_sat)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (c_req || e_req) begin
                    state_d = ISSUE;
                    if (ext_wins) begin
                        gnt_d   = GNT_EXT;
                        wr_d    = ext_wr;
                        addr_d  = ext_addr;
                        wdata_d = ext_wdata;
                        cnt_clr = 1'b1;
                    end else begin
                        gnt_d   = GNT_CPU;
                        wr_d    = cpu_wr;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        cnt_inc = e_req;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = IDLE;
                if (gnt_q == GNT_EXT) begin
                    ext_ack_d = 1'b1;
                    if (!wr_q) begin
                        ext_rdata_d = mem_rdata;
                    end
                end else begin
                    cpu_ack_d = 1'b1;
                    if (!wr_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_CPU;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    // Address and data come from the grant latches, so they hold through WAIT.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = (state_q == ISSUE) & ~wr_q;
    assign mem_wr    = (state_q == ISSUE) & wr_q;

    assign cpu_ack   = cpu_ack_q;
    assign ext_ack   = ext_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter with a transaction-level reference.
// Includes a behavioural 32x8 memory answering one cycle after mem_rd.
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;
    logic          ext_req = 1'b0;
    logic          ext_wr = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic [DW-1:0] ext_rdata;
    logic          ext_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] ram [32];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AWIDTH  (AW),
        .DWIDTH  (DW),
        .MAX_WAIT(MW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack  (cpu_ack),
        .cpu_stall(cpu_stall),
        .ext_req  (ext_req),
        .ext_wr   (ext_wr),
        .ext_addr (ext_addr),
        .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata),
        .ext_ack  (ext_ack),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        if (mem_wr) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    // Reference: one transaction at a time, three cycles from grant to ack.
    logic [DW-1:0] gold [32];
    int            acc_left = 0;
    bit            m_ext = 0;
    bit            m_wr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_exp = '0;
    int            m_lost = 0;
    bit            m_cack = 0;
    bit            m_eack = 0;
    logic [DW-1:0] m_crd = '0;
    logic [DW-1:0] m_erd = '0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        acc_left = 0;
        m_ext = 0;
        m_lost = 0;
        m_cack = 0;
        m_eack = 0;
        m_crd = '0;
        m_erd = '0;
    endtask

    task automatic model_edge();
        bit c;
        bit e;
        if (!rst) begin
            model_reset();
            return;
        end
        c = cpu_req && !m_cack;
        e = ext_req && !m_eack;
        m_cack = 0;
        m_eack = 0;
        if (acc_left == 1) begin
            if (m_ext) begin
                m_eack = 1;
                if (!m_wr) m_erd = m_exp;
            end else begin
                m_cack = 1;
                if (!m_wr) m_crd = m_exp;
            end
            acc_left = 0;
        end else if (acc_left == 2) begin
            acc_left = 1;
        end else if (c || e) begin
            if (e && (!c || m_lost >= MW)) begin
                m_ext = 1;
                m_wr = ext_wr;
                m_addr = ext_addr;
                m_wdata = ext_wdata;
                m_lost = 0;
            end else begin
                m_ext = 0;
                m_wr = cpu_wr;
                m_addr = cpu_addr;
                m_wdata = cpu_wdata;
                if (e && m_lost < MW) m_lost++;
            end
            if (m_wr) gold[m_addr] = m_wdata;
            else m_exp = gold[m_addr];
            acc_left = 2;
        end
    endtask

    task automatic check_outputs();
        chk("cpu_ack", cpu_ack, m_cack);
        chk("ext_ack", ext_ack, m_eack);
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("ext_rdata", ext_rdata, m_erd);
        chk("cpu_stall", cpu_stall, cpu_req & !m_cack);
        chk("mem_rd", mem_rd, acc_left == 2 && !m_wr);
        chk("mem_wr", mem_wr, acc_left == 2 && m_wr);
        if (acc_left != 0) chk("mem_addr", mem_addr, m_addr);
        if (acc_left == 2 && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_cpu(input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd);
        int n;
        cpu_req = 1;
        cpu_wr = wr;
        cpu_addr = a;
        cpu_wdata = d;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (cpu_ack) break;
        end
        chk("cpu_done", cpu_ack, 1);
        chk("cpu_lat", n, 3);
        rd = cpu_rdata;
        cpu_req = 0;
        tick();
    endtask

    task automatic do_ext(input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd);
        int n;
        ext_req = 1;
        ext_wr = wr;
        ext_addr = a;
        ext_wdata = d;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (ext_ack) break;
        end
        chk("ext_done", ext_ack, 1);
        chk("ext_lat", n, 3);
        rd = ext_rdata;
        ext_req = 0;
        tick();
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] exp7;
        bit            prev_ack;
        int            nacks;

        rst = 0;
        for (int i = 0; i < 32; i++) begin
            pl_en = 1;
            pl_addr = AW'(i);
            pl_data = (i == 31) ? 8'h3C : DW'($urandom);
            gold[i] = pl_data;
            tick();
        end
        pl_en = 0;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_cpu_ack", cpu_ack, 0);

        // Reset dropped into the WAIT cycle of a CPU read.
        rst = 1;
        tick();
        cpu_req = 1;
        cpu_wr = 0;
        cpu_addr = 5;
        tick();
        tick();
        chk("wait_mem_addr", mem_addr, 5);
        rst = 0;
        cpu_req = 0;
        #1;
        chk("rstw_cpu_ack", cpu_ack, 0);
        chk("rstw_ext_ack", ext_ack, 0);
        chk("rstw_mem_rd", mem_rd | mem_wr, 0);
        chk("rstw_mem_addr", mem_addr, 0);
        chk("rstw_rdata", {cpu_rdata, ext_rdata}, 0);
        chk("rstw_stall", cpu_stall, 0);
        model_reset();
        @(negedge clk);
        tick();
        chk("rstw_no_ack", cpu_ack, 0);
        rst = 1;
        tick();
        do_cpu(0, 5, 0, rd);
        chk("rst_recover", rd, gold[5]);

        // Write then read back.
        do_cpu(1, 3, 8'hA5, rd);
        do_cpu(0, 3, 0, rd);
        chk("wr_rd_A5", rd, 8'hA5);

        // External-only read of the top address.
        do_ext(0, 31, 0, rd);
        chk("ext_rd_3C", rd, 8'h3C);

        // Inputs changing after the grant must not affect the access.
        exp7 = gold[7];
        cpu_req = 1;
        cpu_wr = 0;
        cpu_addr = 7;
        tick();
        cpu_addr = 9;
        tick();
        chk("mid_mem_addr", mem_addr, 7);
        tick();
        chk("mid_ack", cpu_ack, 1);
        chk("mid_rdata", cpu_rdata, exp7);
        cpu_req = 0;
        tick();

        // CPU request held high: never regranted in its own ack cycle.
        cpu_req = 1;
        cpu_wr = 0;
        prev_ack = 0;
        nacks = 0;
        for (int i = 0; i < 20; i++) begin
            cpu_addr = AW'($urandom);
            tick();
            if (prev_ack) chk("mask_no_regrant", mem_rd | mem_wr, 0);
            prev_ack = cpu_ack;
            if (cpu_ack) nacks++;
        end
        chk("mask_acks", nacks, 5);
        cpu_req = 0;
        tick();
        tick();

        // Free random traffic on both ports.
        for (int i = 0; i < 1500; i++) begin
            cpu_req = ($urandom_range(9) < 6);
            cpu_wr = $urandom_range(1);
            cpu_addr = AW'($urandom);
            cpu_wdata = DW'($urandom);
            ext_req = ($urandom_range(9) < 5);
            ext_wr = $urandom_range(1);
            ext_addr = AW'($urandom);
            ext_wdata = DW'($urandom);
            tick();
        end

        // Both ports held continuously.
        cpu_req = 1;
        ext_req = 1;
        for (int i = 0; i < 48; i++) begin
            cpu_wr = $urandom_range(1);
            ext_wr = $urandom_range(1);
            cpu_addr = AW'($urandom);
            ext_addr = AW'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
